// File: rtl/cu_pkg.sv
// Shared types and constants for the cu_seq instruction-cycle sequencer.
package cu_pkg;

  localparam int CU_PC_STEP = 4;

  typedef enum logic [1:0] {
    CU_KIND_ALU    = 2'd0,
    CU_KIND_BRANCH = 2'd1,
    CU_KIND_JAL    = 2'd2,
    CU_KIND_JALR   = 2'd3
  } cu_kind_t;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXEC    = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } cu_state_t;

  typedef enum logic [1:0] {
    CU_HALT_NONE     = 2'd0,
    CU_HALT_ERR      = 2'd1,
    CU_HALT_LIMIT    = 2'd2,
    CU_HALT_MISALIGN = 2'd3
  } cu_halt_t;

endpackage

// File: rtl/cu_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 hard-wired to zero, whole array cleared by reset.
module cu_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_ra_addr,
  output logic [XLEN-1:0] o_ra_data,
  input  logic [AW-1:0]   i_rb_addr,
  output logic [XLEN-1:0] o_rb_data,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd
);

  logic [XLEN-1:0] r_mem [NREG];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_ra_data = (i_ra_addr == '0) ? '0 : r_mem[i_ra_addr];
  assign o_rb_data = (i_rb_addr == '0) ? '0 : r_mem[i_rb_addr];

endmodule

// File: rtl/cu_seq.sv
// Handshaked fetch/decode/operand/exec/writeback sequencer with sticky halt.
// Optional retired-instruction counter enabled by defining CU_RETIRE_CNT_EN.
module cu_seq
  import cu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int RESET_PC = 0,
  parameter int PC_LIMIT = 512
) (
  input  logic            soc_clk,
  input  logic            reset,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_valid,
  input  logic [31:0]     fetch_instr,
  output logic [31:0]     ir,
  output logic            dec_start,
  input  logic            dec_ready,
  input  logic [1:0]      dec_kind,
  input  logic [4:0]      dec_rd,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [XLEN-1:0] dec_imm,
  input  logic            dec_use_imm,
  input  logic [1:0]      dec_override,
  output logic            alu_start,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic            alu_done,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_flag,
  input  logic            err_in,
  output logic            halted,
  output logic [1:0]      halt_cause,
  output logic [2:0]      dbg_state
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_count
`endif
);

  localparam int AW = $clog2(NREG);
  localparam logic [XLEN-1:0] STEP  = XLEN'(CU_PC_STEP);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(PC_LIMIT);
  localparam logic [XLEN-1:0] PC0   = XLEN'(RESET_PC);

  cu_state_t       r_state, w_next_state;
  cu_halt_t        r_halt_cause, w_cause;
  cu_kind_t        r_kind;
  logic [XLEN-1:0] r_pc, r_imm, r_alu_a, r_alu_b, r_result, r_last_wb;
  logic [31:0]     r_ir;
  logic [AW-1:0]   r_rd, r_rs1, r_rs2;
  logic [1:0]      r_override;
  logic            r_use_imm, r_flag, r_dec_start, r_alu_start;

  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_op_a, w_op_b;
  logic [XLEN-1:0] w_link, w_next_pc, w_wb_data;
  logic            w_wb_en, w_reg_we;

  cu_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_regfile (
    .i_clk     (soc_clk),
    .i_rst     (reset),
    .i_ra_addr (r_rs1),
    .o_ra_data (w_rs1_val),
    .i_rb_addr (r_rs2),
    .o_rb_data (w_rs2_val),
    .i_we      (w_reg_we),
    .i_wa      (r_rd),
    .i_wd      (w_wb_data)
  );

  always_comb begin
    w_op_a = r_override[0] ? r_last_wb : w_rs1_val;
    w_op_b = r_use_imm ? r_imm : w_rs2_val;
    if (r_override[1]) w_op_b = r_last_wb;
  end

  // The JALR base is operand A, so a forwarded value steers the jump too.
  always_comb begin
    w_link    = r_pc + STEP;
    w_next_pc = w_link;
    w_wb_en   = 1'b0;
    w_wb_data = w_link;
    case (r_kind)
      CU_KIND_ALU: begin
        w_wb_en   = 1'b1;
        w_wb_data = r_result;
      end
      CU_KIND_BRANCH: if (r_flag) w_next_pc = r_pc + r_imm;
      CU_KIND_JAL: begin
        w_wb_en   = 1'b1;
        w_next_pc = r_pc + r_imm;
      end
      CU_KIND_JALR: begin
        w_wb_en      = 1'b1;
        w_next_pc    = r_alu_a + r_imm;
        w_next_pc[0] = 1'b0;
      end
      default: w_wb_en = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_cause      = CU_HALT_NONE;
    case (r_state)
      S_FETCH:   if (fetch_valid) w_next_state = S_DECODE;
      S_DECODE:  if (dec_ready) w_next_state = S_OPERAND;
      S_OPERAND: w_next_state = S_EXEC;
      S_EXEC:    if (alu_done) w_next_state = S_WB;
      S_WB: begin
        if (w_next_pc[1:0] != 2'b00) begin
          w_next_state = S_HALT;
          w_cause      = CU_HALT_MISALIGN;
        end else if (w_next_pc >= LIMIT) begin
          w_next_state = S_HALT;
          w_cause      = CU_HALT_LIMIT;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_HALT;
    endcase
    if (err_in && (r_state != S_HALT)) begin
      w_next_state = S_HALT;
      w_cause      = CU_HALT_ERR;
    end
  end

  // The rd write commits even when the new PC halts; only an error blocks it.
  assign w_reg_we = (r_state == S_WB) && !err_in && w_wb_en && (r_rd != '0);

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_halt_cause <= CU_HALT_NONE;
      r_kind       <= CU_KIND_ALU;
      r_pc         <= PC0;
      r_imm        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_result     <= '0;
      r_last_wb    <= '0;
      r_ir         <= '0;
      r_rd         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_override   <= '0;
      r_use_imm    <= 1'b0;
      r_flag       <= 1'b0;
      r_dec_start  <= 1'b0;
      r_alu_start  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_dec_start <= (r_state == S_FETCH) && (w_next_state == S_DECODE);
      r_alu_start <= (r_state == S_OPERAND) && (w_next_state == S_EXEC);
      if ((r_state == S_FETCH) && (w_next_state == S_DECODE)) r_ir <= fetch_instr;
      if ((r_state == S_DECODE) && (w_next_state == S_OPERAND)) begin
        r_kind     <= cu_kind_t'(dec_kind);
        r_rd       <= dec_rd[AW-1:0];
        r_rs1      <= dec_rs1[AW-1:0];
        r_rs2      <= dec_rs2[AW-1:0];
        r_imm      <= dec_imm;
        r_use_imm  <= dec_use_imm;
        r_override <= dec_override;
      end
      if ((r_state == S_OPERAND) && (w_next_state == S_EXEC)) begin
        r_alu_a <= w_op_a;
        r_alu_b <= w_op_b;
      end
      if ((r_state == S_EXEC) && (w_next_state == S_WB)) begin
        r_result <= alu_result;
        r_flag   <= alu_flag;
      end
      if ((r_state == S_WB) && (w_next_state == S_FETCH)) r_pc <= w_next_pc;
      if (w_reg_we) r_last_wb <= w_wb_data;
      if ((r_state != S_HALT) && (w_next_state == S_HALT)) r_halt_cause <= w_cause;
    end
  end

`ifdef CU_RETIRE_CNT_EN
  logic [31:0] r_retire_count;

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      r_retire_count <= '0;
    end else if ((r_state == S_WB) && (w_next_state == S_FETCH) && (r_retire_count != 32'hFFFF_FFFF)) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign retire_count = r_retire_count;
`endif

  assign fetch_req  = (r_state == S_FETCH) && !reset;
  assign fetch_addr = r_pc;
  assign ir         = r_ir;
  assign dec_start  = r_dec_start;
  assign alu_start  = r_alu_start;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign halted     = (r_state == S_HALT);
  assign halt_cause = r_halt_cause;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cu_seq.sv
// Self-checking bench for cu_seq: directed vector table, hand-written corner
// sequences, and random instructions checked against an architectural model.
module tb_cu_seq;
  import cu_pkg::*;

  logic        soc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_instr = '0;
  logic [31:0] ir;
  logic        dec_start;
  logic        dec_ready = 1'b0;
  logic [1:0]  dec_kind = '0;
  logic [4:0]  dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
  logic [31:0] dec_imm = '0;
  logic        dec_use_imm = 1'b0;
  logic [1:0]  dec_override = '0;
  logic        alu_start;
  logic [31:0] alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [31:0] alu_result = '0;
  logic        alu_flag = 1'b0;
  logic        err_in = 1'b0;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [2:0]  dbg_state;

  cu_seq #(.XLEN(32), .NREG(32), .RESET_PC(0), .PC_LIMIT(512)) dut (
    .soc_clk(soc_clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .ir(ir),
    .dec_start(dec_start), .dec_ready(dec_ready), .dec_kind(dec_kind),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm),
    .dec_use_imm(dec_use_imm), .dec_override(dec_override),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_flag(alu_flag), .err_in(err_in),
    .halted(halted), .halt_cause(halt_cause), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 soc_clk = ~soc_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // Architectural reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_last_wb;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0;
    m_last_wb = '0;
  endfunction

  task automatic step();
    @(negedge soc_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_valid = 1'b0; dec_ready = 1'b0; alu_done = 1'b0; err_in = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    m_reset();
  endtask

  // Drives one instruction through all handshakes and checks the observable
  // effects. exp_cause != 0 means the instruction must halt the sequencer.
  task automatic do_instr(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input logic use_imm,
                          input logic [1:0] ovr, input logic [31:0] res, input logic flag,
                          input logic err, input int fw, input int dw, input int aw,
                          input logic [31:0] cur_pc, input logic [31:0] exp_a,
                          input logic [31:0] exp_b, input logic [31:0] exp_pc,
                          input logic [1:0] exp_cause);
    logic [31:0] word;
    word = $urandom;
    check("fetch_req", 32'(fetch_req), 32'd1);
    check("fetch_addr", fetch_addr, cur_pc);
    for (int i = 0; i < fw; i++) begin
      fetch_valid = 1'b0; dec_ready = 1'b1; alu_done = 1'b1;
      step();
      check("fetch_wait_state", 32'(dbg_state), 32'(S_FETCH));
    end
    dec_ready = 1'b0; alu_done = 1'b0;
    fetch_valid = 1'b1; fetch_instr = word;
    step();
    fetch_valid = 1'b0; fetch_instr = $urandom;
    check("dec_start", 32'(dec_start), 32'd1);
    check("ir", ir, word);
    for (int i = 0; i < dw; i++) begin
      alu_done = 1'b1; fetch_valid = 1'b1;
      step();
      if (i == 0) check("dec_start_no_repulse", 32'(dec_start), 32'd0);
    end
    alu_done = 1'b0; fetch_valid = 1'b0;
    dec_kind = kind; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_imm = imm; dec_use_imm = use_imm; dec_override = ovr; dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    dec_kind = 2'($urandom); dec_rd = 5'($urandom); dec_rs1 = 5'($urandom);
    dec_rs2 = 5'($urandom); dec_imm = $urandom; dec_override = 2'($urandom);
    check("operand_state", 32'(dbg_state), 32'(S_OPERAND));
    step();
    check("alu_start", 32'(alu_start), 32'd1);
    check("alu_a", alu_a, exp_a);
    check("alu_b", alu_b, exp_b);
    for (int i = 0; i < aw; i++) begin
      fetch_valid = 1'b1; dec_ready = 1'b1;
      step();
      if (i == 0) check("alu_start_no_repulse", 32'(alu_start), 32'd0);
    end
    fetch_valid = 1'b0; dec_ready = 1'b0;
    alu_done = 1'b1; alu_result = res; alu_flag = flag; err_in = err;
    step();
    alu_done = 1'b0; err_in = 1'b0; alu_result = $urandom; alu_flag = 1'($urandom);
    if (!err) step();
    if (exp_cause != 2'd0) begin
      check("halted", 32'(halted), 32'd1);
      check("halt_cause", 32'(halt_cause), 32'(exp_cause));
      check("halt_pc_frozen", fetch_addr, cur_pc);
      check("halt_fetch_req", 32'(fetch_req), 32'd0);
    end else begin
      check("not_halted", 32'(halted), 32'd0);
      check("next_pc", fetch_addr, exp_pc);
      check("back_to_fetch", 32'(dbg_state), 32'(S_FETCH));
    end
  endtask

  // In HALT every handshake input, including err_in, must be ignored.
  task automatic halt_inert(input logic [1:0] exp_cause);
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1; dec_ready = 1'b1; alu_done = 1'b1; err_in = (i == 1);
      step();
    end
    fetch_valid = 1'b0; dec_ready = 1'b0; alu_done = 1'b0; err_in = 1'b0;
    check("halt_sticky_state", 32'(dbg_state), 32'(S_HALT));
    check("halt_sticky_req", 32'(fetch_req), 32'd0);
    check("halt_sticky_dec_start", 32'(dec_start), 32'd0);
    check("halt_sticky_alu_start", 32'(alu_start), 32'd0);
    check("halt_sticky_cause", 32'(halt_cause), 32'(exp_cause));
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        ui;
    logic [1:0]  ovr;
    logic [31:0] res;
    logic        flag;
    logic [31:0] cur_pc, exp_a, exp_b, exp_pc;
    logic [1:0]  cause;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [1:0]  kind, ovr, cause;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, res, ea, eb, npc, link, val, pc_before;
    logic        ui, flag, err, wr;
    int          k;

    //           rst  kind rd  rs1 rs2 imm        ui ovr    res        fl cur      a        b        pc       cause
    tbl[0]  = '{1'b1, 2'd0, 5,  0,  0, 32'h10,    1, 2'b00, 32'h10,    0, 32'h0,   32'h0,   32'h10,  32'h4,   2'd0};
    tbl[1]  = '{1'b0, 2'd0, 6,  0,  5, 32'h0,     0, 2'b01, 32'h99,    0, 32'h4,   32'h10,  32'h10,  32'h8,   2'd0};
    tbl[2]  = '{1'b0, 2'd1, 7,  5,  6, 32'h20,    0, 2'b00, 32'h55,    1, 32'h8,   32'h10,  32'h99,  32'h28,  2'd0};
    tbl[3]  = '{1'b0, 2'd3, 0,  0,  0, 32'h8,     1, 2'b00, 32'h0,     0, 32'h28,  32'h0,   32'h8,   32'h8,   2'd0};
    tbl[4]  = '{1'b0, 2'd1, 7,  7,  6, 32'h20,    0, 2'b10, 32'h0,     0, 32'h8,   32'h0,   32'h99,  32'hC,   2'd0};
    tbl[5]  = '{1'b0, 2'd2, 2,  5,  0, 32'h4,     1, 2'b00, 32'h0,     0, 32'hC,   32'h10,  32'h4,   32'h10,  2'd0};
    tbl[6]  = '{1'b0, 2'd2, 1,  2,  0, 32'h40,    1, 2'b00, 32'h0,     0, 32'h10,  32'h10,  32'h40,  32'h50,  2'd0};
    tbl[7]  = '{1'b0, 2'd0, 3,  9,  9, 32'h0,     0, 2'b11, 32'h101,   0, 32'h50,  32'h14,  32'h14,  32'h54,  2'd0};
    tbl[8]  = '{1'b0, 2'd3, 4,  3,  0, 32'h0,     1, 2'b00, 32'h0,     0, 32'h54,  32'h101, 32'h0,   32'h100, 2'd0};
    tbl[9]  = '{1'b0, 2'd0, 8,  1,  4, 32'h0,     0, 2'b00, 32'h102,   0, 32'h100, 32'h14,  32'h58,  32'h104, 2'd0};
    tbl[10] = '{1'b0, 2'd3, 9,  8,  0, 32'h0,     1, 2'b00, 32'h0,     0, 32'h104, 32'h102, 32'h0,   32'h0,   2'd3};
    tbl[11] = '{1'b1, 2'd2, 1,  0,  0, 32'h200,   1, 2'b00, 32'h0,     0, 32'h0,   32'h0,   32'h200, 32'h0,   2'd2};
    tbl[12] = '{1'b1, 2'd2, 0,  0,  0, 32'h1F8,   1, 2'b00, 32'h0,     0, 32'h0,   32'h0,   32'h1F8, 32'h1F8, 2'd0};
    tbl[13] = '{1'b0, 2'd0, 1,  0,  0, 32'h4,     1, 2'b00, 32'h7,     0, 32'h1F8, 32'h0,   32'h4,   32'h1FC, 2'd0};
    tbl[14] = '{1'b0, 2'd0, 2,  0,  0, 32'h0,     1, 2'b01, 32'h3,     0, 32'h1FC, 32'h7,   32'h0,   32'h0,   2'd2};

    // Reset values and idle FETCH with out-of-state handshakes ignored
    reset = 1'b1;
    step();
    check("rst_fetch_req", 32'(fetch_req), 32'd0);
    check("rst_fetch_addr", fetch_addr, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_starts", 32'({dec_start, alu_start}), 32'd0);
    check("rst_alu_ops", alu_a | alu_b, 32'h0);
    check("rst_halt", 32'({halted, halt_cause}), 32'd0);
    reset = 1'b0;
    m_reset();
    dec_ready = 1'b1; alu_done = 1'b1;
    repeat (3) step();
    dec_ready = 1'b0; alu_done = 1'b0;
    check("idle_state", 32'(dbg_state), 32'(S_FETCH));
    check("idle_fetch_req", 32'(fetch_req), 32'd1);
    check("idle_fetch_addr", fetch_addr, 32'h0);
    check("idle_dec_start", 32'(dec_start), 32'd0);

    // Directed vector table, zero-wait responders (5-cycle instructions)
    for (int t = 0; t < 15; t++) begin
      if (tbl[t].rst) do_reset();
      do_instr(tbl[t].kind, tbl[t].rd, tbl[t].rs1, tbl[t].rs2, tbl[t].imm, tbl[t].ui,
               tbl[t].ovr, tbl[t].res, tbl[t].flag, 1'b0, 0, 0, 0, tbl[t].cur_pc,
               tbl[t].exp_a, tbl[t].exp_b, tbl[t].exp_pc, tbl[t].cause);
      if (t == 10) halt_inert(2'd3);
    end

    // Error coincident with alu_done: halt with cause 1, no writeback
    do_reset();
    do_instr(2'd0, 5'd5, 5'd0, 5'd0, 32'h0, 1'b1, 2'b00, 32'h33, 1'b0, 1'b0, 1, 2, 1,
             32'h0, 32'h0, 32'h0, 32'h4, 2'd0);
    do_instr(2'd0, 5'd5, 5'd5, 5'd0, 32'h8, 1'b1, 2'b00, 32'h77, 1'b0, 1'b1, 0, 0, 0,
             32'h4, 32'h33, 32'h8, 32'h0, 2'd1);
    halt_inert(2'd1);

    // Reset in the middle of EXEC aborts and clears the register file
    do_reset();
    do_instr(2'd0, 5'd5, 5'd0, 5'd0, 32'h44, 1'b1, 2'b00, 32'h44, 1'b0, 1'b0, 0, 0, 0,
             32'h0, 32'h0, 32'h44, 32'h4, 2'd0);
    fetch_valid = 1'b1; step(); fetch_valid = 1'b0;
    dec_kind = 2'd2; dec_rd = 5'd5; dec_imm = 32'h40; dec_ready = 1'b1; step(); dec_ready = 1'b0;
    step();
    alu_done = 1'b1;
    reset = 1'b1;
    #1;
    check("midrst_pc", fetch_addr, 32'h0);
    check("midrst_state", 32'(dbg_state), 32'(S_FETCH));
    check("midrst_alu_start", 32'(alu_start), 32'd0);
    alu_done = 1'b0;
    step();
    reset = 1'b0;
    step();
    m_reset();
    do_instr(2'd0, 5'd6, 5'd5, 5'd0, 32'h0, 1'b1, 2'b00, 32'h1, 1'b0, 1'b0, 0, 0, 0,
             32'h0, 32'h0, 32'h0, 32'h4, 2'd0);
    m_regs[6] = 32'h1; m_last_wb = 32'h1; m_pc = 32'h4;

    // Random instructions against the architectural model
    for (int n = 0; n < 220; n++) begin
      k = $urandom_range(0, 9);
      kind = (k <= 5) ? 2'd0 : (k == 6) ? 2'd1 : (k <= 8) ? 2'd2 : 2'd3;
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      ui = 1'($urandom); ovr = 2'($urandom); flag = 1'($urandom);
      res = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 120) * 4) : $urandom;
      if (kind == 2'd0) imm = $urandom;
      else if (kind == 2'd3) imm = 32'($urandom_range(0, 64));
      else if ($urandom_range(0, 7) == 0) imm = 32'($urandom_range(0, 255));
      else imm = 32'($urandom_range(0, 32) * 4) - 32'd64;
      if (kind == 2'd3) ovr[0] = 1'b0;
      err = ($urandom_range(0, 24) == 0);

      pc_before = m_pc;
      ea = ovr[0] ? m_last_wb : m_regs[rs1];
      eb = ovr[1] ? m_last_wb : (ui ? imm : m_regs[rs2]);
      link = m_pc + 32'd4;
      wr = 1'b1; val = link; npc = link;
      case (kind)
        2'd0: val = res;
        2'd1: begin wr = 1'b0; if (flag) npc = m_pc + imm; end
        2'd2: npc = m_pc + imm;
        default: npc = (ea + imm) & 32'hFFFF_FFFE;
      endcase
      if (err) begin
        cause = 2'd1;
      end else begin
        if (wr && rd != 5'd0) begin
          m_regs[rd] = val;
          m_last_wb = val;
        end
        if (npc % 4 != 0) cause = 2'd3;
        else if (npc >= 32'd512) cause = 2'd2;
        else cause = 2'd0;
        if (cause == 2'd0) m_pc = npc;
      end
      exp_q.push_back((cause == 2'd0) ? npc : pc_before);
      do_instr(kind, rd, rs1, rs2, imm, ui, ovr, res, flag, err,
               ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 2),
               ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 2),
               ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 2),
               pc_before, ea, eb, npc, cause);
      check("pc_trace", fetch_addr, exp_q.pop_front());
      if (cause != 2'd0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cu_seq.md
# cu_seq

Parametrised instruction-cycle sequencer for the control unit. It supersedes the fixed 4-count control loop with a handshaked FSM: fetch, decode, operand select with result forwarding, execute, then writeback with PC update. It owns the architectural register file and PC, and drives the memory-fetch, decode and ALU blocks. It halts permanently on error, a PC-limit breach or a misaligned jump target.

## Interface

**Parameters**
- `XLEN`, 32: datapath and PC width.
- `NREG`, 32: number of architectural registers. Power of two, ≤32.
- `RESET_PC`, 0: PC value loaded at reset.
- `PC_LIMIT`, 512: first illegal PC. `PC >= PC_LIMIT` halts.

**Ports**
- `soc_clk` in 1: clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `fetch_req` out 1: fetch request. Held high in FETCH until `fetch_valid`.
- `fetch_addr` out XLEN: current PC.
- `fetch_valid` in 1: instruction word present.
- `fetch_instr` in 32: instruction word, latched into the IR.
- `ir` out 32: instruction register, feeds the decoder.
- `dec_start` out 1: one-cycle pulse on entry to DECODE.
- `dec_ready` in 1: decode fields valid.
- `dec_kind` in 2: 0 = ALU, 1 = BRANCH, 2 = JAL, 3 = JALR.
- `dec_rd`, `dec_rs1`, `dec_rs2` in 5 each: register selects. Only the low `$clog2(NREG)` bits are used.
- `dec_imm` in XLEN: sign-extended immediate.
- `dec_use_imm` in 1: operand B = imm instead of rs2.
- `dec_override` in 2: bit0 forwards the last writeback value to A; bit1 forwards it to B.
- `alu_start` out 1: one-cycle pulse on entry to EXEC.
- `alu_a`, `alu_b` out XLEN: operands.
- `alu_done` in 1: ALU result valid.
- `alu_result` in XLEN: ALU result.
- `alu_flag` in 1: branch condition true.
- `err_in` in 1: OR of ALU error and invalid instruction.
- `halted` out 1: sticky halt.
- `halt_cause` out 2: 0 = none, 1 = error, 2 = PC limit, 3 = misaligned target.

## Operation

**States:** FETCH → DECODE → OPERAND → EXEC → WB → FETCH, plus HALT.

- **FETCH**
  - Drives `fetch_req = 1` and `fetch_addr = PC`.
  - On `fetch_valid`, latches IR and moves to DECODE.
- **DECODE**
  - Pulses `dec_start` on the entry cycle only.
  - Waits for `dec_ready`, latches all decode fields, then moves to OPERAND.
- **OPERAND**
  - A = rs1 value; B = imm when `dec_use_imm`, else rs2 value.
  - An override bit replaces its operand with `last_wb`. Both bits may be set together.
  - Register x0 always reads 0.
  - Registers `alu_a` and `alu_b`, then moves to EXEC.
- **EXEC**
  - Pulses `alu_start` on the entry cycle.
  - Waits for `alu_done`, latches result and flag, then moves to WB.
- **WB**, by instruction kind:
  - ALU: rd ← result; next PC = PC+4.
  - BRANCH: no register write; next PC = flag ? PC+imm : PC+4.
  - JAL: rd ← PC+4; next PC = PC+imm.
  - JALR: rd ← PC+4; next PC = (rs1 + imm) & ~1.
  - Writes to x0 are discarded.
  - `last_wb` ← the written value. It is not updated when no write occurs.
- **Arithmetic:** modulo 2^XLEN; wrap-around is not flagged.
- **Halt checks**, evaluated on the computed next PC before it is committed:
  - `next_pc[1:0] != 0` → HALT, cause 3.
  - Otherwise `next_pc >= PC_LIMIT` → HALT, cause 2.
  - The rd write still commits in both cases.
- **Errors:** `err_in` high in any non-HALT state → HALT next edge, cause 1. It takes priority over every other transition, so in EXEC no writeback occurs.
- **HALT:**
  - Absorbing until reset.
  - Request, start and pulse outputs are 0; PC and registers are frozen.
  - `halt_cause` holds the first cause.

## Timing

- **Reset values:** all outputs are 0, except `fetch_addr = RESET_PC`. Registers, IR and `last_wb` are cleared; state = FETCH.
- **Reset mid-instruction:** aborts immediately. No register write and no PC change.
- **Minimum latency** is 5 cycles per instruction, when `fetch_valid`, `dec_ready` and `alu_done` are each high in the first cycle of their state.
- **Stall:** each wait state holds indefinitely. `dec_start` and `alu_start` are never re-pulsed while waiting.
- **Ignored inputs:** `fetch_valid`, `dec_ready` and `alu_done` are ignored outside their own states.

## Configuration

- `CU_RETIRE_CNT_EN` defined:
  - Adds output `retire_count` (out, 32 bits).
  - Increments on every WB that does not halt; saturates at 0xFFFF_FFFF; reset to 0.
- `CU_RETIRE_CNT_EN` undefined: no port and no counter logic.

## Structure

- Package `cu_pkg` holds:
  - `cu_kind_t` (ALU/BRANCH/JAL/JALR).
  - `cu_state_t`.
  - `cu_halt_t`.
  - Constant `CU_PC_STEP = 4`.
- Sub-module `cu_regfile`:
  - NREG × XLEN storage, two asynchronous read ports, one synchronous write port.
  - x0 hard-wired to zero; asynchronous clear on `reset`.

## Test plan

- **Reset/idle:** reset with `RESET_PC = 0`, drive `fetch_valid = 0` → `fetch_req = 1`, `fetch_addr = 0`, state stays FETCH.
- **ALU plus forwarding:**
  - Stimulus: instr1 rd = x5, result 0x10; instr2 `dec_override = 2'b01`, rs1 = x0.
  - Required: `alu_a = 0x10`; PC 0 → 4 → 8; each instruction takes 5 cycles with zero-wait responders.
- **Branch:**
  - At PC 8 with imm = 0x20: `alu_flag = 1` → PC = 0x28; `alu_flag = 0` → PC = 0xC.
  - x registers unchanged.
- **JAL/JALR:**
  - JAL at PC 0x10, imm 0x40, rd = x1 → x1 = 0x14, PC = 0x50.
  - JALR with rs1 = 0x101, imm 0 → PC = 0x100.
  - JALR target 0x102 → HALT, cause 3.
- **PC limit:** JAL to 0x200 with `PC_LIMIT = 512` → `halted = 1`, `halt_cause = 2`, rd written.
- **Error during EXEC:** `err_in` pulsed in the same cycle as `alu_done` → HALT, cause 1, rd unchanged. A later `fetch_valid` is ignored until reset.
